mac_result_drain: RTL and testbench



---
 rtl/cnn_acc_pkg.sv | 21 ++
 rtl/mac_result_drain_if.sv | 38 +++
 rtl/mac_result_drain_requant_lane.sv | 56 +++++
 rtl/mac_result_drain.sv | 104 ++++++++++
 tb/tb_mac_result_drain.sv | 368 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cnn_acc_pkg.sv
// Shared constants and types for the CNN accumulator datapath.
// Holds the default lane geometry, the lane-index width helper and the
// result-drain state encoding used by mac_result_drain and its neighbours.
package cnn_acc_pkg;

  localparam int unsigned DEF_NUM_MAC   = 4;
  localparam int unsigned DEF_ACC_WIDTH = 16;
  localparam int unsigned DEF_OUT_WIDTH = 8;
  localparam int unsigned DEF_SHIFT_W   = 4;

  // Width of an index over n items, never narrower than one bit.
  function automatic int unsigned lane_idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } drain_state_e;

endpackage

// File: rtl/mac_result_drain_if.sv
// Capture and output handshake bundle for mac_result_drain.
//   capture side : cap_valid/cap_ready, acc_in, shift, relu_en
//   output side  : out_valid/out_ready, out_data, out_lane, out_last, out_sat
// master = surrounding environment (MAC array + writeback), slave = the drain.
interface mac_result_drain_if
  import cnn_acc_pkg::*;
#(
  parameter int unsigned NUM_MAC   = DEF_NUM_MAC,
  parameter int unsigned ACC_WIDTH = DEF_ACC_WIDTH,
  parameter int unsigned OUT_WIDTH = DEF_OUT_WIDTH,
  parameter int unsigned SHIFT_W   = DEF_SHIFT_W
) ();

  localparam int unsigned LANE_W = lane_idx_w(NUM_MAC);

  logic                         cap_valid;
  logic                         cap_ready;
  logic [NUM_MAC*ACC_WIDTH-1:0] acc_in;
  logic [SHIFT_W-1:0]           shift;
  logic                         relu_en;
  logic                         out_valid;
  logic                         out_ready;
  logic [OUT_WIDTH-1:0]         out_data;
  logic [LANE_W-1:0]            out_lane;
  logic                         out_last;
  logic                         out_sat;

  modport master (
    output cap_valid, acc_in, shift, relu_en, out_ready,
    input  cap_ready, out_valid, out_data, out_lane, out_last, out_sat
  );

  modport slave (
    input  cap_valid, acc_in, shift, relu_en, out_ready,
    output cap_ready, out_valid, out_data, out_lane, out_last, out_sat
  );

endinterface

// File: rtl/mac_result_drain_requant_lane.sv
// Combinational requantizer for one accumulator lane:
// optional ReLU, round-half-up arithmetic right shift, signed saturation.
//   x_i        signed accumulator lane
//   shift_i    already-clamped shift amount (0..ACC_WIDTH-1)
//   relu_en_i  clamp negative inputs to zero
//   data_c_o   saturated OUT_WIDTH result
//   sat_c_o    high when the result was clamped
module requant_lane #(
  parameter int unsigned ACC_WIDTH = 16,
  parameter int unsigned OUT_WIDTH = 8,
  parameter int unsigned SH_W      = 4
) (
  input  logic signed [ACC_WIDTH-1:0] x_i,
  input  logic        [SH_W-1:0]      shift_i,
  input  logic                        relu_en_i,
  output logic signed [OUT_WIDTH-1:0] data_c_o,
  output logic                        sat_c_o
);

  // One guard bit so the rounding add cannot wrap.
  localparam int unsigned EW = ACC_WIDTH + 1;
  localparam logic signed [EW-1:0] SAT_MAX = EW'((64'd1 << (OUT_WIDTH - 1)) - 64'd1);
  localparam logic signed [EW-1:0] SAT_MIN = ~SAT_MAX;

  logic signed [ACC_WIDTH-1:0] xr;
  logic signed [EW-1:0]        xe;
  logic        [EW-1:0]        rnd;
  logic signed [EW-1:0]        sum;
  logic signed [EW-1:0]        t;

  // ReLU, round, shift, saturate.
  always_comb begin
    xr       = (relu_en_i && x_i[ACC_WIDTH-1]) ? '0 : x_i;
    xe       = {xr[ACC_WIDTH-1], xr};
    rnd      = '0;
    sum      = xe;
    t        = xe;
    data_c_o = '0;
    sat_c_o  = 1'b0;
    if (shift_i != '0) begin
      rnd = EW'(1) << (shift_i - SH_W'(1));
      sum = xe + rnd;
      t   = sum >>> shift_i;
    end
    if (t > SAT_MAX) begin
      data_c_o = SAT_MAX[OUT_WIDTH-1:0];
      sat_c_o  = 1'b1;
    end else if (t < SAT_MIN) begin
      data_c_o = SAT_MIN[OUT_WIDTH-1:0];
      sat_c_o  = 1'b1;
    end else begin
      data_c_o = t[OUT_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/mac_result_drain.sv
// Captures one NUM_MAC x ACC_WIDTH accumulator vector and streams its lanes,
// lane 0 first, through a shared requantizer onto a valid/ready port.
//   clk, rst  single clock, synchronous active-high reset
//   bus       mac_result_drain_if slave: capture handshake in, lane beats out
// The next capture is accepted on the same cycle the last beat is taken,
// so consecutive vectors stream with no bubble.
module mac_result_drain
  import cnn_acc_pkg::*;
#(
  parameter int unsigned NUM_MAC   = DEF_NUM_MAC,
  parameter int unsigned ACC_WIDTH = DEF_ACC_WIDTH,
  parameter int unsigned OUT_WIDTH = DEF_OUT_WIDTH,
  parameter int unsigned SHIFT_W   = DEF_SHIFT_W
) (
  input logic               clk,
  input logic               rst,
  mac_result_drain_if.slave bus
);

  localparam int unsigned LANE_W = lane_idx_w(NUM_MAC);
  localparam int unsigned SH_W   = lane_idx_w(ACC_WIDTH);
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(NUM_MAC - 1);

  drain_state_e                 state_q;
  logic [LANE_W-1:0]            lane_q;
  logic [NUM_MAC*ACC_WIDTH-1:0] acc_q;
  logic [SH_W-1:0]              shift_q;
  logic                         relu_q;

  logic                         sending;
  logic                         at_last;
  logic                         cap_fire;
  logic                         beat_fire;
  logic [SH_W-1:0]              shift_clamped;
  logic signed [ACC_WIDTH-1:0]  lane_x;
  logic signed [OUT_WIDTH-1:0]  lane_data;
  logic                         lane_sat;

  assign sending   = (state_q == SEND);
  assign at_last   = (lane_q == LAST_LANE);
  assign beat_fire = sending && bus.out_ready;
  assign cap_fire  = bus.cap_valid && bus.cap_ready;

  // Shifts past the accumulator width collapse to the widest meaningful one.
  assign shift_clamped = (32'(bus.shift) > (ACC_WIDTH - 1)) ? SH_W'(ACC_WIDTH - 1)
                                                            : SH_W'(bus.shift);

  // Ready in IDLE, or in SEND exactly when the final beat is being taken.
  assign bus.cap_ready = !rst && (!sending || (at_last && bus.out_ready));

  // Drain FSM plus holding registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      lane_q  <= '0;
      acc_q   <= '0;
      shift_q <= '0;
      relu_q  <= 1'b0;
    end else if (cap_fire) begin
      state_q <= SEND;
      lane_q  <= '0;
      acc_q   <= bus.acc_in;
      shift_q <= shift_clamped;
      relu_q  <= bus.relu_en;
    end else if (beat_fire) begin
      if (at_last) begin
        state_q <= IDLE;
        lane_q  <= '0;
      end else begin
        lane_q  <= lane_q + LANE_W'(1);
      end
    end
  end

  // Select the current lane from the holding register.
  always_comb begin
    lane_x = '0;
    for (int unsigned i = 0; i < NUM_MAC; i++) begin
      if (lane_q == LANE_W'(i)) begin
        lane_x = acc_q[i*ACC_WIDTH +: ACC_WIDTH];
      end
    end
  end

  requant_lane #(
    .ACC_WIDTH (ACC_WIDTH),
    .OUT_WIDTH (OUT_WIDTH),
    .SH_W      (SH_W)
  ) u_requant (
    .x_i       (lane_x),
    .shift_i   (shift_q),
    .relu_en_i (relu_q),
    .data_c_o  (lane_data),
    .sat_c_o   (lane_sat)
  );

  // Beat fields depend only on registered state, so they hold during stalls.
  assign bus.out_valid = sending;
  assign bus.out_data  = sending ? lane_data : '0;
  assign bus.out_lane  = sending ? lane_q    : '0;
  assign bus.out_last  = sending && at_last;
  assign bus.out_sat   = sending && lane_sat;

endmodule

// File: tb/tb_mac_result_drain.sv
// Self-checking bench for mac_result_drain: directed vectors from the
// requantization rules plus randomized vectors, each checked beat by beat
// against an integer reference model.
module tb_mac_result_drain;
  import cnn_acc_pkg::*;

  localparam int unsigned NM = 4;
  localparam int unsigned AW = 16;
  localparam int unsigned OW = 8;
  localparam int unsigned SW = 4;
  localparam int unsigned LW = 2;

  typedef struct {
    int data;
    int lane;
    bit last;
    bit sat;
  } beat_t;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  beat_t exp_q[$];

  always #5 clk = ~clk;

  mac_result_drain_if #(.NUM_MAC(NM), .ACC_WIDTH(AW), .OUT_WIDTH(OW), .SHIFT_W(SW)) bus_if ();

  mac_result_drain #(.NUM_MAC(NM), .ACC_WIDTH(AW), .OUT_WIDTH(OW), .SHIFT_W(SW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  // Reference: requantize one lane with plain integer arithmetic.
  function automatic void model_lane(input int x_in, input int s_in, input bit relu,
                                     output int d, output bit sat);
    int x;
    int s;
    int t;
    x = x_in;
    s = (s_in > int'(AW) - 1) ? int'(AW) - 1 : s_in;
    if (relu && x < 0) x = 0;
    if (s > 0) t = (x + (1 << (s - 1))) >>> s;
    else       t = x;
    sat = 1'b0;
    if (t > 127) begin
      t = 127;  sat = 1'b1;
    end else if (t < -128) begin
      t = -128; sat = 1'b1;
    end
    d = t;
  endfunction

  // Queue the expected beats of a whole vector.
  function automatic void model_vec(input logic [NM*AW-1:0] v, input int s, input bit relu);
    beat_t b;
    logic signed [AW-1:0] lane_v;
    for (int i = 0; i < int'(NM); i++) begin
      lane_v = v[i*AW +: AW];
      model_lane(int'(lane_v), s, relu, b.data, b.sat);
      b.lane = i;
      b.last = (i == int'(NM) - 1);
      exp_q.push_back(b);
    end
  endfunction

  // Capture one vector and drain it; mode 0 = always ready, 1 = 1,0,0 pattern, 2 = random.
  task automatic run_vector(input string name, input logic [NM*AW-1:0] vec,
                            input int s, input bit relu, input int mode);
    int    cyc;
    bit    rdy;
    bit    prev_stall;
    logic [OW-1:0] prev_data;
    logic [LW-1:0] prev_lane;
    beat_t h;
    bus_if.cap_valid = 1'b1;
    bus_if.acc_in    = vec;
    bus_if.shift     = SW'(s);
    bus_if.relu_en   = relu;
    bus_if.out_ready = 1'b0;
    #1;
    checks++;
    if (bus_if.cap_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s idle_cap_ready got=%b want=1", name, bus_if.cap_ready);
    end
    model_vec(vec, s, relu);
    @(negedge clk);
    bus_if.cap_valid = 1'b0;
    bus_if.shift     = SW'($urandom);
    bus_if.relu_en   = 1'($urandom);
    cyc = 0;
    prev_stall = 1'b0;
    prev_data = '0;
    prev_lane = '0;
    while (exp_q.size() > 0 && cyc < 64) begin
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 3 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      bus_if.out_ready = rdy;
      #1;
      h = exp_q[0];
      checks++;
      if (bus_if.out_valid !== 1'b1) begin
        errors++;
        $display("FAIL %s out_valid cyc=%0d got=%b want=1", name, cyc, bus_if.out_valid);
      end
      checks++;
      if (bus_if.out_data !== OW'(h.data) || bus_if.out_lane !== LW'(h.lane) ||
          bus_if.out_last !== h.last || bus_if.out_sat !== h.sat) begin
        errors++;
        $display("FAIL %s beat lane%0d got data=%0d lane=%0d last=%b sat=%b want data=%0d lane=%0d last=%b sat=%b",
                 name, h.lane, $signed(bus_if.out_data), bus_if.out_lane, bus_if.out_last,
                 bus_if.out_sat, h.data, h.lane, h.last, h.sat);
      end
      checks++;
      if (bus_if.cap_ready !== (rdy && h.last)) begin
        errors++;
        $display("FAIL %s cap_ready cyc=%0d got=%b want=%b", name, cyc, bus_if.cap_ready, rdy && h.last);
      end
      if (prev_stall) begin
        checks++;
        if (bus_if.out_data !== prev_data || bus_if.out_lane !== prev_lane) begin
          errors++;
          $display("FAIL %s stall_hold got data=%0d lane=%0d want data=%0d lane=%0d",
                   name, $signed(bus_if.out_data), bus_if.out_lane, $signed(prev_data), prev_lane);
        end
      end
      prev_stall = !rdy;
      prev_data  = bus_if.out_data;
      prev_lane  = bus_if.out_lane;
      if (rdy) void'(exp_q.pop_front());
      @(negedge clk);
      cyc++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s timeout beats_left=%0d want=0", name, exp_q.size());
      exp_q.delete();
    end
    bus_if.out_ready = 1'b0;
    #1;
    checks++;
    if (bus_if.out_valid !== 1'b0 || bus_if.cap_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s back_to_idle got valid=%b cap_ready=%b want valid=0 cap_ready=1",
               name, bus_if.out_valid, bus_if.cap_ready);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus_if.cap_valid = 1'b1;
    bus_if.acc_in    = {$urandom, $urandom};
    bus_if.shift     = '0;
    bus_if.relu_en   = 1'b0;
    bus_if.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (bus_if.out_valid !== 1'b0 || bus_if.out_last !== 1'b0 || bus_if.out_sat !== 1'b0 ||
        bus_if.out_lane !== '0 || bus_if.out_data !== '0) begin
      errors++;
      $display("FAIL reset_outputs got valid=%b last=%b sat=%b lane=%0d data=%0d want all 0",
               bus_if.out_valid, bus_if.out_last, bus_if.out_sat, bus_if.out_lane, bus_if.out_data);
    end
    checks++;
    if (bus_if.cap_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_cap_ready got=%b want=0", bus_if.cap_ready);
    end
    bus_if.cap_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (bus_if.cap_ready !== 1'b1 || bus_if.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release got cap_ready=%b valid=%b want cap_ready=1 valid=0",
               bus_if.cap_ready, bus_if.out_valid);
    end
    @(negedge clk);
  endtask

  task automatic test_basic();
    run_vector("basic", {16'h0003, 16'h7FFF, 16'hFF00, 16'h0100}, 2, 1'b0, 0);
  endtask

  task automatic test_relu_round();
    logic [NM*AW-1:0] v;
    run_vector("relu", {16'h0003, 16'h7FFF, 16'hFF00, 16'h0100}, 2, 1'b1, 0);
    v = {$urandom, $urandom};
    v[AW-1:0] = 16'hFFFB;
    run_vector("round_neg", v, 1, 1'b0, 0);
  endtask

  task automatic test_shift_edges();
    logic [NM*AW-1:0] v;
    run_vector("shift0_sat", {16'hFF7F, 16'hFF70, 16'h0090, 16'h0050}, 0, 1'b0, 0);
    v = {$urandom, $urandom};
    v[AW-1:0] = 16'h7FFF;
    run_vector("shift15", v, 15, 1'b0, 0);
  endtask

  task automatic test_backpressure();
    run_vector("backpressure", {$urandom, $urandom}, 3, 1'b0, 1);
  endtask

  task automatic test_random();
    for (int k = 0; k < 12; k++) begin
      run_vector("random", {$urandom, $urandom}, int'($urandom_range(0, 15)),
                 1'($urandom), 2);
    end
  endtask

  task automatic test_back_to_back();
    logic [NM*AW-1:0] v1;
    logic [NM*AW-1:0] v2;
    int s2;
    bit r2;
    bit pushed2;
    int cyc;
    beat_t h;
    v1 = {$urandom, $urandom};
    v2 = {$urandom, $urandom};
    s2 = int'($urandom_range(0, 15));
    r2 = 1'($urandom);
    bus_if.cap_valid = 1'b1;
    bus_if.acc_in    = v1;
    bus_if.shift     = SW'(4);
    bus_if.relu_en   = 1'b0;
    bus_if.out_ready = 1'b1;
    #1;
    model_vec(v1, 4, 1'b0);
    @(negedge clk);
    bus_if.acc_in  = v2;
    bus_if.shift   = SW'(s2);
    bus_if.relu_en = r2;
    pushed2 = 1'b0;
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 64) begin
      #1;
      h = exp_q[0];
      checks++;
      if (bus_if.out_valid !== 1'b1) begin
        errors++;
        $display("FAIL b2b out_valid cyc=%0d got=%b want=1", cyc, bus_if.out_valid);
      end
      checks++;
      if (bus_if.out_data !== OW'(h.data) || bus_if.out_lane !== LW'(h.lane) ||
          bus_if.out_last !== h.last || bus_if.out_sat !== h.sat) begin
        errors++;
        $display("FAIL b2b beat cyc=%0d got data=%0d lane=%0d last=%b sat=%b want data=%0d lane=%0d last=%b sat=%b",
                 cyc, $signed(bus_if.out_data), bus_if.out_lane, bus_if.out_last, bus_if.out_sat,
                 h.data, h.lane, h.last, h.sat);
      end
      checks++;
      if (bus_if.cap_ready !== h.last) begin
        errors++;
        $display("FAIL b2b cap_ready cyc=%0d got=%b want=%b", cyc, bus_if.cap_ready, h.last);
      end
      void'(exp_q.pop_front());
      if (h.last && !pushed2) begin
        model_vec(v2, s2, r2);
        pushed2 = 1'b1;
      end
      @(negedge clk);
      if (pushed2) begin
        bus_if.cap_valid = 1'b0;
        bus_if.shift     = SW'($urandom);
        bus_if.relu_en   = 1'($urandom);
      end
      cyc++;
    end
    checks++;
    if (exp_q.size() != 0 || cyc != 2 * int'(NM)) begin
      errors++;
      $display("FAIL b2b beat_count got cycles=%0d left=%0d want cycles=%0d left=0",
               cyc, exp_q.size(), 2 * NM);
      exp_q.delete();
    end
    #1;
    checks++;
    if (bus_if.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b idle got valid=%b want=0", bus_if.out_valid);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_send();
    bit saw_last;
    saw_last = 1'b0;
    bus_if.cap_valid = 1'b1;
    bus_if.acc_in    = {$urandom, $urandom};
    bus_if.shift     = SW'(2);
    bus_if.relu_en   = 1'b0;
    bus_if.out_ready = 1'b1;
    @(negedge clk);
    bus_if.cap_valid = 1'b0;
    // lanes 0 and 1 accepted on the next two edges
    repeat (2) begin
      #1;
      if (bus_if.out_last === 1'b1) saw_last = 1'b1;
      @(negedge clk);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (bus_if.cap_ready !== 1'b0) begin
      errors++;
      $display("FAIL midrst cap_ready_in_rst got=%b want=0", bus_if.cap_ready);
    end
    @(negedge clk);
    #1;
    checks++;
    if (bus_if.out_valid !== 1'b0 || bus_if.out_last !== 1'b0) begin
      errors++;
      $display("FAIL midrst after_edge got valid=%b last=%b want 0 0", bus_if.out_valid, bus_if.out_last);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (bus_if.cap_ready !== 1'b1) begin
      errors++;
      $display("FAIL midrst cap_ready_after got=%b want=1", bus_if.cap_ready);
    end
    repeat (3) begin
      @(negedge clk);
      #1;
      if (bus_if.out_last === 1'b1 || bus_if.out_valid === 1'b1) saw_last = 1'b1;
    end
    checks++;
    if (saw_last) begin
      errors++;
      $display("FAIL midrst aborted_vector got out_last/valid seen=1 want=0");
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    bus_if.cap_valid = 1'b0;
    bus_if.acc_in    = '0;
    bus_if.shift     = '0;
    bus_if.relu_en   = 1'b0;
    bus_if.out_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_relu_round();
    test_shift_edges();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_reset_mid_send();
    test_basic();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
